// File: rtl/verinject_fault_scheduler_if.sv
// verinject_fault_scheduler_if: configuration port and injector-state bus of the fault scheduler
interface verinject_fault_scheduler_if #(parameter int ADDR_W = 3);
  logic              cfg_we;
  logic [ADDR_W-1:0] cfg_addr;
  logic [31:0]       cfg_cycle;
  logic [31:0]       cfg_bit;
  logic              start;
  logic [ADDR_W:0]   num_entries;
  logic              abort;
  logic [31:0]       verinject__injector_state;
  logic              inject_valid;
  logic              busy;
  logic              done;
  logic [ADDR_W:0]   fired_count;
  logic [ADDR_W:0]   late_count;
  modport master (
    output cfg_we, cfg_addr, cfg_cycle, cfg_bit, start, num_entries, abort,
    input  verinject__injector_state, inject_valid, busy, done, fired_count, late_count
  );
  modport slave (
    input  cfg_we, cfg_addr, cfg_cycle, cfg_bit, start, num_entries, abort,
    output verinject__injector_state, inject_valid, busy, done, fired_count, late_count
  );
endinterface

// File: rtl/verinject_fault_scheduler.sv
// verinject_fault_scheduler: replays a table of (trigger cycle, bit index) pairs onto the injector-state bus
module verinject_fault_scheduler #(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3
) (
  input logic                           clock,
  input logic                           reset_n,
  verinject_fault_scheduler_if.slave    bus
);
  localparam logic [31:0]     NONE    = 32'hFFFF_FFFF;
  localparam logic [ADDR_W:0] DEPTH_N = DEPTH[ADDR_W:0];
  typedef enum logic {IDLE, RUN} state_t;
  state_t          state;
  logic [31:0]     cycle_tab [DEPTH];
  logic [31:0]     bit_tab   [DEPTH];
  logic [31:0]     count;
  logic [ADDR_W:0] ptr;
  logic [ADDR_W:0] n;
  logic [ADDR_W:0] n_req;
  logic            fin;
  logic [31:0]     trig;
  logic [31:0]     next_bit;
  logic            fire;
  logic            addr_ok;
  assign n_req    = bus.num_entries > DEPTH_N ? DEPTH_N : bus.num_entries;
  assign trig     = cycle_tab[ptr[ADDR_W-1:0]];
  assign next_bit = bit_tab[ptr[ADDR_W-1:0]];
  assign fire     = count >= trig;
  assign addr_ok  = int'(bus.cfg_addr) < DEPTH;
  // schedule table: written only while idle, never reset
  always_ff @(posedge clock)
    if (bus.cfg_we && state == IDLE && addr_ok) begin
      cycle_tab[bus.cfg_addr] <= bus.cfg_cycle;
      bit_tab[bus.cfg_addr]   <= bus.cfg_bit;
    end
  // run control: cycle counting, in-order firing, abort and done sequencing
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      state                         <= IDLE;
      count                         <= '0;
      ptr                           <= '0;
      n                             <= '0;
      fin                           <= 1'b0;
      bus.verinject__injector_state <= NONE;
      bus.inject_valid              <= 1'b0;
      bus.busy                      <= 1'b0;
      bus.done                      <= 1'b0;
      bus.fired_count               <= '0;
      bus.late_count                <= '0;
    end else begin
      bus.verinject__injector_state <= NONE;
      bus.inject_valid              <= 1'b0;
      bus.done                      <= fin;
      fin                           <= 1'b0;
      if (state == IDLE) begin
        if (bus.start) begin
          bus.fired_count <= '0;
          bus.late_count  <= '0;
          if (n_req == '0) bus.done <= 1'b1;
          else begin
            state    <= RUN;
            bus.busy <= 1'b1;
            count    <= '0;
            ptr      <= '0;
            n        <= n_req;
          end
        end
      end else if (bus.abort) begin
        state    <= IDLE;
        bus.busy <= 1'b0;
      end else begin
        count <= count == NONE ? count : count + 32'd1;
        if (fire) begin
          bus.verinject__injector_state <= next_bit;
          bus.inject_valid              <= next_bit != NONE;
          bus.fired_count               <= bus.fired_count + 1'b1;
          if (count > trig) bus.late_count <= bus.late_count + 1'b1;
          ptr <= ptr + 1'b1;
          if (ptr + 1'b1 == n) begin
            state    <= IDLE;
            bus.busy <= 1'b0;
            fin      <= 1'b1;
          end
        end
      end
    end
endmodule

// File: tb/tb_verinject_fault_scheduler.sv
// tb_verinject_fault_scheduler: directed scenarios checked every cycle against a fire-time schedule model
module tb_verinject_fault_scheduler;
  localparam logic [31:0] NONE = 32'hFFFF_FFFF;
  localparam longint FAR = 64'h0FFF_FFFF_FFFF_FFFF;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int failures = 0;
  longint edge_n = 0;
  verinject_fault_scheduler_if #(.ADDR_W(3)) sif ();
  verinject_fault_scheduler #(.DEPTH(8), .ADDR_W(3)) dut (.clock(clk), .reset_n(rst_n), .bus(sif.slave));
  always #5 clk = ~clk;
  logic [31:0] m_cyc [8];
  logic [31:0] m_bit [8];
  longint      f     [8];
  bit          lt    [8];
  logic [31:0] rbit  [8];
  longint      e0 = 0;
  longint      abort_e = FAR;
  int          n_run = 0;
  bit          run_valid = 1'b0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at edge %0d: got %0h expected %0h", nm, edge_n, act, exp);
    end
  endtask
  // Expected outputs in the cycle following edge e, derived from the precomputed fire edges.
  function automatic void predict(input longint e, output logic [31:0] b, output logic bz, output logic d,
                                  output int fc, output int lc);
    b = NONE; bz = 1'b0; d = 1'b0; fc = 0; lc = 0;
    if (!run_valid || e < e0) return;
    if (n_run == 0) begin
      d = (e == e0);
      return;
    end
    for (int k = 0; k < n_run; k++)
      if (f[k] <= e && f[k] < abort_e) begin
        fc++;
        lc += int'(lt[k]);
        if (f[k] == e) b = rbit[k];
      end
    bz = e < f[n_run-1] && e < abort_e;
    d  = e == f[n_run-1] + 1 && f[n_run-1] < abort_e;
  endfunction
  function automatic bit busy_at(input longint e);
    logic [31:0] b;
    logic bz, d;
    int fc, lc;
    predict(e, b, bz, d, fc, lc);
    return bz;
  endfunction
  always @(posedge clk) begin
    logic [31:0] eb;
    logic ebz, ed;
    int efc, elc;
    edge_n++;
    #2;
    predict(edge_n, eb, ebz, ed, efc, elc);
    chk("bus", sif.verinject__injector_state, eb);
    chk("inject_valid", {31'd0, sif.inject_valid}, {31'd0, eb != NONE});
    chk("busy", {31'd0, sif.busy}, {31'd0, ebz});
    chk("done", {31'd0, sif.done}, {31'd0, ed});
    chk("fired_count", {28'd0, sif.fired_count}, efc);
    chk("late_count", {28'd0, sif.late_count}, elc);
  end
  task automatic wait_edge(input longint t);
    while (edge_n < t) begin
      @(posedge clk);
      #3;
    end
  endtask
  task automatic wr(input int a, input logic [31:0] c, input logic [31:0] b);
    @(negedge clk);
    sif.cfg_we = 1'b1; sif.cfg_addr = a[2:0]; sif.cfg_cycle = c; sif.cfg_bit = b;
    if (!busy_at(edge_n)) begin
      m_cyc[a] = c;
      m_bit[a] = b;
    end
    @(negedge clk);
    sif.cfg_we = 1'b0;
  endtask
  task automatic go(input logic [3:0] n, output longint s);
    longint t;
    @(negedge clk);
    sif.start = 1'b1; sif.num_entries = n;
    s = edge_n + 1;
    if (!busy_at(edge_n)) begin
      run_valid = 1'b1; e0 = s; abort_e = FAR;
      n_run = n > 4'd8 ? 8 : int'(n);
      for (int k = 0; k < n_run; k++) begin
        t = s + longint'(m_cyc[k]) + 1;
        f[k] = (k > 0 && f[k-1] + 1 > t) ? f[k-1] + 1 : t;
        lt[k] = f[k] > t;
        rbit[k] = m_bit[k];
      end
    end
    @(negedge clk);
    sif.start = 1'b0;
  endtask
  task automatic kill(input bit with_start);
    @(negedge clk);
    sif.abort = 1'b1; sif.start = with_start; sif.num_entries = 4'd1;
    if (busy_at(edge_n)) abort_e = edge_n + 1;
    @(negedge clk);
    sif.abort = 1'b0; sif.start = 1'b0;
  endtask
  task automatic case_basic();
    longint s;
    wr(0, 3, 100); wr(1, 7, 42);
    go(2, s);
    wait_edge(s + 4); chk("t1 bus@E0+4", sif.verinject__injector_state, 100);
    wait_edge(s + 5); chk("t1 bus@E0+5", sif.verinject__injector_state, NONE);
    wait_edge(s + 8); chk("t1 bus@E0+8", sif.verinject__injector_state, 42);
    wait_edge(s + 9); chk("t1 done@E0+9", {31'd0, sif.done}, 1);
    chk("t1 fired", {28'd0, sif.fired_count}, 2);
    chk("t1 late", {28'd0, sif.late_count}, 0);
    wait_edge(s + 11);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end
  initial begin
    longint s, s2;
    sif.cfg_we = 1'b0; sif.cfg_addr = '0; sif.cfg_cycle = '0; sif.cfg_bit = '0;
    sif.start = 1'b0; sif.num_entries = '0; sif.abort = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset bus", sif.verinject__injector_state, NONE);
    chk("reset busy", {31'd0, sif.busy}, 0);
    rst_n = 1'b1;
    case_basic();
    wr(0, 5, 1); wr(1, 5, 2); wr(2, 5, 3);
    go(3, s);
    wait_edge(s + 6); chk("t2 bus@E0+6", sif.verinject__injector_state, 1);
    wait_edge(s + 8); chk("t2 bus@E0+8", sif.verinject__injector_state, 3);
    wait_edge(s + 9); chk("t2 late", {28'd0, sif.late_count}, 2);
    wait_edge(s + 11);
    wr(0, 10, 9); wr(1, 2, 8);
    go(2, s);
    wait_edge(s + 11); chk("t3 bus@E0+11", sif.verinject__injector_state, 9);
    wait_edge(s + 12); chk("t3 bus@E0+12", sif.verinject__injector_state, 8);
    wait_edge(s + 13); chk("t3 late", {28'd0, sif.late_count}, 1);
    wait_edge(s + 15);
    wr(0, 20, 5);
    go(1, s);
    wait_edge(s + 9);
    kill(1'b1);
    chk("t4 busy after abort", {31'd0, sif.busy}, 0);
    wait_edge(s + 30);
    chk("t4 fired", {28'd0, sif.fired_count}, 0);
    go(0, s);
    wait_edge(s); chk("t5 done N=0", {31'd0, sif.done}, 1);
    wait_edge(s + 2);
    go(1, s);
    wait_edge(s + 2);
    wr(0, 1, 77);
    wait_edge(s + 24);
    go(1, s2);
    wait_edge(s2 + 2); chk("t6 no early fire", {31'd0, sif.inject_valid}, 0);
    wait_edge(s2 + 21); chk("t6 old entry", sif.verinject__injector_state, 5);
    wait_edge(s2 + 23);
    for (int k = 0; k < 8; k++) wr(k, k, 200 + k);
    go(4'd9, s);
    wait_edge(s + 1); chk("t7 first", sif.verinject__injector_state, 200);
    wait_edge(s + 9); chk("t7 clamp fired", {28'd0, sif.fired_count}, 8);
    chk("t7 done", {31'd0, sif.done}, 1);
    wait_edge(s + 11);
    wr(0, 1, NONE); wr(1, 2, 33);
    go(2, s);
    wait_edge(s + 2); chk("t8 silent valid", {31'd0, sif.inject_valid}, 0);
    wait_edge(s + 3); chk("t8 bus", sif.verinject__injector_state, 33);
    wait_edge(s + 4); chk("t8 fired", {28'd0, sif.fired_count}, 2);
    wait_edge(s + 6);
    wr(0, 3, 100); wr(1, 7, 42);
    go(2, s);
    wait_edge(s + 3);
    rst_n = 1'b0;
    #1;
    run_valid = 1'b0; abort_e = FAR;
    chk("t9 reset bus", sif.verinject__injector_state, NONE);
    chk("t9 reset busy", {31'd0, sif.busy}, 0);
    chk("t9 reset fired", {28'd0, sif.fired_count}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    case_basic();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
